// File: rtl/instr_mem_loader_pkg.sv
// Debug/loader constants shared by the program loader, the debug unit and
// the decode-stage halt detection.
package instr_mem_loader_pkg;

   // Default datapath geometry
   localparam int DBG_N_BITS  = 8;    // UART byte width
   localparam int DBG_NB_DATA = 32;   // instruction word width
   localparam int DBG_NB_ADDR = 7;    // instruction memory word-address width

   // Debug command byte codes received over the UART
   localparam logic [7:0] DBG_CMD_LOAD  = 8'h4C;  // 'L' : program load
   localparam logic [7:0] DBG_CMD_RUN   = 8'h52;  // 'R' : run pipeline
   localparam logic [7:0] DBG_CMD_STEP  = 8'h53;  // 'S' : single step
   localparam logic [7:0] DBG_CMD_DUMP  = 8'h44;  // 'D' : dump data memory
   localparam logic [7:0] DBG_CMD_REGS  = 8'h47;  // 'G' : dump register file

   // Instruction word that ends a program (also detected by decode)
   localparam logic [31:0] DBG_HALT_WORD = 32'hFFFF_FFFF;

   // Idle cycles tolerated in the middle of a word before it is discarded
   localparam int DBG_TIMEOUT_CYC = 100000;

   // Loader state encoding
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } loader_state_t;

   // True when the byte is the program-load command
   function automatic logic is_load_cmd(input logic [7:0] b);
      return b == DBG_CMD_LOAD;
   endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Loader bus: UART byte stream in, instruction-memory write port and
// load status out. The loader sits on the slave side.
interface instr_mem_loader_if
   import instr_mem_loader_pkg::*;
#(
   parameter int N_BITS  = DBG_N_BITS,
   parameter int NB_DATA = DBG_NB_DATA,
   parameter int NB_ADDR = DBG_NB_ADDR
);
   // UART receiver side
   logic [N_BITS-1:0]  rx_data_i;
   logic               rx_done_i;

   // Instruction memory write port
   logic               wr_en_o;
   logic [NB_ADDR-1:0] wr_addr_o;
   logic [NB_DATA-1:0] wr_data_o;

   // Status towards the debug unit
   logic               loading_o;
   logic               load_done_o;
   logic               full_o;
   logic               timeout_o;
   logic [NB_ADDR:0]   words_loaded_o;

   // Byte source / status consumer
   modport master (
      output rx_data_i, rx_done_i,
      input  wr_en_o, wr_addr_o, wr_data_o,
      input  loading_o, load_done_o, full_o, timeout_o, words_loaded_o
   );

   // Program loader
   modport slave (
      input  rx_data_i, rx_done_i,
      output wr_en_o, wr_addr_o, wr_data_o,
      output loading_o, load_done_o, full_o, timeout_o, words_loaded_o
   );

endinterface

// File: rtl/instr_mem_loader.sv
// Program loader: after a load command byte, packs UART bytes MSB-first
// into instruction words and writes them to consecutive word addresses
// starting at 0, until the halt word is written or memory is full.
module instr_mem_loader
   import instr_mem_loader_pkg::*;
#(
   parameter int                  N_BITS      = DBG_N_BITS,
   parameter int                  NB_DATA     = DBG_NB_DATA,
   parameter int                  NB_ADDR     = DBG_NB_ADDR,
   parameter logic [N_BITS-1:0]   CMD_LOAD    = DBG_CMD_LOAD,
   parameter logic [NB_DATA-1:0]  HALT_WORD   = DBG_HALT_WORD,
   parameter int                  TIMEOUT_CYC = DBG_TIMEOUT_CYC
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   instr_mem_loader_if.slave    bus
);

   localparam int BYTES_PER_WORD = NB_DATA / N_BITS;
   localparam int BCW            = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
   localparam int TW             = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [BCW-1:0]     LAST_BYTE  = BCW'(BYTES_PER_WORD - 1);
   localparam logic [TW-1:0]      IDLE_LIMIT = TW'(TIMEOUT_CYC - 1);
   localparam logic [NB_ADDR-1:0] ADDR_LAST  = '1;

   loader_state_t        state, state_next;

   logic [NB_DATA-1:0]   shift_q;       // byte assembler
   logic [BCW-1:0]       byte_cnt_q;    // bytes of the current word so far
   logic [TW-1:0]        idle_cnt_q;    // silent cycles inside a word
   logic [NB_ADDR-1:0]   addr_q;        // address of the next word
   logic [NB_ADDR-1:0]   wr_addr_q;
   logic [NB_DATA-1:0]   wr_data_q;
   logic [NB_ADDR:0]     words_q;
   logic                 full_q;
   logic                 timeout_q;

   // Decoded per-cycle events
   logic                 strobe;
   logic                 cmd_seen;
   logic                 last_byte;
   logic                 timeout_hit;
   logic                 set_full;
   logic [NB_DATA-1:0]   shift_in;

   assign strobe    = bus.rx_done_i;
   assign cmd_seen  = strobe && (bus.rx_data_i == CMD_LOAD);
   assign last_byte = (byte_cnt_q == LAST_BYTE);
   assign shift_in  = {shift_q[NB_DATA-N_BITS-1:0], bus.rx_data_i};

   // State register
   always_ff @(posedge clock_i) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      if (!reset_i) state <= ST_IDLE;
      else          state <= state_next;
   end

   // Next-state logic and single-cycle decisions
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a value unassigned and no latch is inferred.
      state_next  = state;
      timeout_hit = 1'b0;
      set_full    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (cmd_seen) state_next = ST_RECV;
         end
         ST_RECV: begin
            if (strobe) begin
               if (last_byte) state_next = ST_WRITE;
            end else if (byte_cnt_q != '0 && idle_cnt_q == IDLE_LIMIT) begin
               timeout_hit = 1'b1;
               state_next  = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (wr_data_q == HALT_WORD) begin
               state_next = ST_DONE;
            end else if (addr_q == ADDR_LAST) begin
               set_full   = 1'b1;
               state_next = ST_DONE;
            end else begin
               state_next = ST_RECV;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Byte assembly, addressing, word count and status registers
   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         shift_q    <= '0;
         byte_cnt_q <= '0;
         idle_cnt_q <= '0;
         addr_q     <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         words_q    <= '0;
         full_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         timeout_q <= timeout_hit;
         unique case (state)
            ST_IDLE: begin
               if (cmd_seen) begin
                  shift_q    <= '0;
                  byte_cnt_q <= '0;
                  idle_cnt_q <= '0;
                  addr_q     <= '0;
                  words_q    <= '0;
                  full_q     <= 1'b0;
               end
            end
            ST_RECV: begin
               if (strobe) begin
                  shift_q    <= shift_in;
                  idle_cnt_q <= '0;
                  if (last_byte) begin
                     wr_data_q  <= shift_in;
                     wr_addr_q  <= addr_q;
                     byte_cnt_q <= '0;
                  end else begin
                     byte_cnt_q <= byte_cnt_q + 1'b1;
                  end
               end else if (byte_cnt_q != '0) begin
                  if (timeout_hit) begin
                     shift_q    <= '0;
                     byte_cnt_q <= '0;
                     idle_cnt_q <= '0;
                  end else begin
                     idle_cnt_q <= idle_cnt_q + 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               words_q    <= words_q + 1'b1;
               idle_cnt_q <= '0;
               if (set_full) full_q <= 1'b1;
               if (state_next == ST_RECV) addr_q <= addr_q + 1'b1;
               // A byte arriving during the write starts the next word
               if (strobe) begin
                  shift_q    <= shift_in;
                  byte_cnt_q <= BCW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.wr_en_o        = (state == ST_WRITE);
   assign bus.wr_addr_o      = wr_addr_q;
   assign bus.wr_data_o      = wr_data_q;
   assign bus.loading_o      = (state == ST_RECV) || (state == ST_WRITE);
   assign bus.load_done_o    = (state == ST_DONE);
   assign bus.full_o         = full_q;
   assign bus.timeout_o      = timeout_q;
   assign bus.words_loaded_o = words_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed scenarios plus
// randomized loads compared against a word-level reference model.
module tb_instr_mem_loader;
   import instr_mem_loader_pkg::*;

   localparam int          T     = 16;
   localparam int          DEPTH = 128;
   localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   instr_mem_loader_if #(.N_BITS(8), .NB_DATA(32), .NB_ADDR(7)) bus ();

   instr_mem_loader #(
      .N_BITS(8), .NB_DATA(32), .NB_ADDR(7),
      .CMD_LOAD(8'h4C), .HALT_WORD(32'hFFFF_FFFF), .TIMEOUT_CYC(T)
   ) dut (
      .clock_i (clk),
      .reset_i (rst_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   // Monitor: log writes, strobes and pulses on the falling edge
   int          cyc = 0;
   logic [6:0]  mon_addr[$];
   logic [31:0] mon_data[$];
   int          wr_cyc[$];
   int          strobe_cyc[$];
   int          done_cnt = 0;
   int          done_cyc = 0;
   int          to_cnt   = 0;

   always @(negedge clk) begin
      cyc++;
      if (bus.rx_done_i) strobe_cyc.push_back(cyc);
      if (bus.wr_en_o) begin
         mon_addr.push_back(bus.wr_addr_o);
         mon_data.push_back(bus.wr_data_o);
         wr_cyc.push_back(cyc);
      end
      if (bus.load_done_o) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (bus.timeout_o) to_cnt++;
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Snapshot of monitor progress at the start of a scenario
   int wr_base, st_base, done_base, to_base;
   task automatic mark();
      wr_base   = mon_data.size();
      st_base   = strobe_cyc.size();
      done_base = done_cnt;
      to_base   = to_cnt;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bus.rx_data_i = b;
      bus.rx_done_i = 1'b1;
      tick();
      bus.rx_done_i = 1'b0;
      bus.rx_data_i = 8'($urandom);
      repeat (gap) tick();
   endtask

   // Reference model: bytes after the command are grouped MSB-first into
   // words written from address 0; stop after the halt word or at DEPTH.
   logic [7:0]  stream[$];
   logic [31:0] exp_data[$];
   logic        exp_full;

   task automatic model_load();
      logic [31:0] w;
      exp_data.delete();
      exp_full = 1'b0;
      for (int i = 0; i + 3 < stream.size(); i += 4) begin
         w = {stream[i], stream[i+1], stream[i+2], stream[i+3]};
         exp_data.push_back(w);
         if (w == HALT) break;
         if (exp_data.size() == DEPTH) begin
            exp_full = 1'b1;
            break;
         end
      end
   endtask

   task automatic send_stream(input int max_gap);
      for (int i = 0; i < stream.size(); i++)
         send_byte(stream[i], $urandom_range(0, max_gap));
   endtask

   task automatic push_word(input logic [31:0] w);
      stream.push_back(w[31:24]);
      stream.push_back(w[23:16]);
      stream.push_back(w[15:8]);
      stream.push_back(w[7:0]);
   endtask

   task automatic wait_done(input string tag, input int budget);
      for (int i = 0; i < budget && done_cnt == done_base; i++) tick();
      repeat (3) tick();
      check({tag, "_done_pulses"}, done_cnt - done_base, 1);
   endtask

   task automatic compare_writes(input string tag);
      int n;
      n = mon_data.size() - wr_base;
      check({tag, "_nwrites"}, n, exp_data.size());
      for (int i = 0; i < n && i < exp_data.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), mon_addr[wr_base+i], i);
         check($sformatf("%s_data%0d", tag, i), mon_data[wr_base+i], exp_data[i]);
      end
      check({tag, "_words"}, bus.words_loaded_o, exp_data.size());
      check({tag, "_full"}, bus.full_o, exp_full);
      check({tag, "_loading"}, bus.loading_o, 0);
   endtask

   initial begin
      bus.rx_data_i = '0;
      bus.rx_done_i = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_wr_en",   bus.wr_en_o, 0);
      check("rst_addr",    bus.wr_addr_o, 0);
      check("rst_data",    bus.wr_data_o, 0);
      check("rst_loading", bus.loading_o, 0);
      check("rst_done",    bus.load_done_o, 0);
      check("rst_full",    bus.full_o, 0);
      check("rst_timeout", bus.timeout_o, 0);
      check("rst_words",   bus.words_loaded_o, 0);
      rst_n = 1'b1;
      tick();

      // Reset mid-operation
      mark();
      send_byte(8'h4C, 1);
      check("mid_loading_before", bus.loading_o, 1);
      send_byte(8'hAA, 1);
      send_byte(8'hBB, 0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mid_loading", bus.loading_o, 0);
      check("mid_words",   bus.words_loaded_o, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      repeat (4) tick();
      check("mid_no_write", mon_data.size() - wr_base, 0);

      // Basic load with latency checks
      mark();
      stream = '{8'h20, 8'h08, 8'h00, 8'h05};
      push_word(HALT);
      model_load();
      send_byte(8'h4C, 1);
      send_stream(2);
      wait_done("basic", 50);
      compare_writes("basic");
      check("basic_wr0_lat",  wr_cyc[wr_base],   strobe_cyc[st_base+4] + 1);
      check("basic_wr1_lat",  wr_cyc[wr_base+1], strobe_cyc[st_base+8] + 1);
      check("basic_done_lat", done_cyc,          wr_cyc[wr_base+1] + 1);

      // Noise before the command byte
      mark();
      send_byte(8'h12, 1);
      send_byte(8'h00, 1);
      repeat (3) tick();
      check("noise_no_write", mon_data.size() - wr_base, 0);
      stream = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      push_word(HALT);
      model_load();
      send_byte(8'h4C, 0);
      send_stream(1);
      wait_done("noise", 50);
      compare_writes("noise");

      // Back-to-back strobes, 5th byte during WRITE
      mark();
      stream = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      push_word(HALT);
      model_load();
      send_byte(8'h4C, 0);
      send_stream(0);
      wait_done("b2b", 50);
      compare_writes("b2b");

      // Memory full
      mark();
      stream.delete();
      for (int i = 0; i < DEPTH; i++) push_word(32'h0000_0001);
      model_load();
      send_byte(8'h4C, 0);
      send_stream(0);
      wait_done("full", 50);
      compare_writes("full");
      check("full_last_addr", bus.wr_addr_o, DEPTH - 1);

      // Timeout on a partial word
      mark();
      send_byte(8'h4C, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      send_byte(8'h56, 0);
      send_byte(8'h78, 1);
      send_byte(8'h9A, 1);
      send_byte(8'hBC, 0);
      repeat (T - 2) tick();
      check("to_not_early", to_cnt - to_base, 0);
      repeat (6) tick();
      check("to_pulses",  to_cnt - to_base, 1);
      check("to_nwrites", mon_data.size() - wr_base, 1);
      check("to_data",    mon_data[wr_base], 32'h1234_5678);
      check("to_words",   bus.words_loaded_o, 1);
      check("to_loading", bus.loading_o, 0);
      check("to_no_done", done_cnt - done_base, 0);
      send_byte(8'hAB, 0);
      send_byte(8'hCD, 0);
      send_byte(8'hEF, 0);
      send_byte(8'h01, 0);
      repeat (4) tick();
      check("to_idle_no_write", mon_data.size() - wr_base, 1);

      // Randomized loads against the reference model
      for (int it = 0; it < 20; it++) begin
         logic [31:0] w;
         logic [7:0]  b;
         mark();
         for (int k = 0; k < $urandom_range(0, 3); k++) begin
            b = 8'($urandom);
            if (b == 8'h4C) b = 8'h4D;
            send_byte(b, $urandom_range(0, 2));
         end
         stream.delete();
         for (int k = 0; k < $urandom_range(0, 5); k++) begin
            w = $urandom;
            if (w == HALT) w = 32'h0;
            push_word(w);
         end
         push_word(HALT);
         model_load();
         send_byte(8'h4C, 0);
         check($sformatf("rnd%0d_loading", it), bus.loading_o, 1);
         send_stream(3);
         wait_done($sformatf("rnd%0d", it), 50);
         compare_writes($sformatf("rnd%0d", it));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Sits upstream of the instruction memory in the fetch stage. Consumes the byte stream from the UART receiver and feeds the program-load path of the debug unit.
- On a load command byte, it assembles 4 received bytes (MSB first) into a 32-bit word per write. It issues single-cycle word writes at consecutive word addresses from 0.
- Loading ends on the halt word or when memory is full. The block then reports the number of words written and a done pulse, so the debug unit can enable the pipeline.

Parameters:
- N_BITS, 8, UART byte width
- NB_DATA, 32, instruction word width
- NB_ADDR, 7, instruction memory word-address width (depth 2^NB_ADDR)
- CMD_LOAD, 8'h4C, command byte that starts a program load
- HALT_WORD, 32'hFFFF_FFFF, instruction word that terminates loading
- TIMEOUT_CYC, 100000, idle cycles allowed mid-word before the partial word is discarded

Ports:
- clock_i, in, 1, system clock
- reset_i, in, 1, synchronous active-low reset
- rx_data_i, in, N_BITS, received byte; valid only while rx_done_i=1
- rx_done_i, in, 1, one-cycle strobe: rx_data_i holds a new byte
- wr_en_o, out, 1, one-cycle write strobe to instruction memory
- wr_addr_o, out, NB_ADDR, word address for the write
- wr_data_o, out, NB_DATA, assembled instruction word
- loading_o, out, 1, high from command accept until done or abort
- load_done_o, out, 1, one-cycle pulse when loading completes normally
- full_o, out, 1, sticky; set when loading ended because the last address was written without a halt word
- timeout_o, out, 1, one-cycle pulse when a partial word is discarded
- words_loaded_o, out, NB_ADDR+1, count of words written in the last load; held until the next CMD_LOAD

Behaviour:
- Clock and reset: one clock, clock_i. Reset is synchronous and active-low on reset_i; all registers update only on the rising edge of clock_i.
- Reset values: state=IDLE, all outputs 0, internal shift register, byte counter, address counter and idle counter all 0.
- State IDLE:
  - rx_done_i with rx_data_i==CMD_LOAD → RECV. Clear address, byte counter, words_loaded_o and full_o; set loading_o.
  - Any other byte is ignored.
- State RECV, on rx_done_i:
  - shift <= {shift[23:0], rx_data_i}; byte_cnt++.
  - On the 4th byte (byte_cnt==3 before increment): latch the word into wr_data_o, clear byte_cnt, go to WRITE.
- State WRITE (exactly 1 cycle):
  - wr_en_o=1, wr_addr_o=current address; words_loaded_o++.
  - Next state:
    - if wr_data_o==HALT_WORD → DONE;
    - else if address==2^NB_ADDR-1 → DONE and set full_o;
    - else address++ → RECV.
  - A byte strobed during WRITE is not lost: it is shifted in as byte 0 of the next word.
  - The halt word itself is written to memory.
- State DONE (1 cycle): load_done_o=1, loading_o cleared, → IDLE. A strobe arriving in DONE is ignored.
- Latency: wr_en_o asserts on the cycle after the 4th-byte strobe. load_done_o asserts on the cycle after the final wr_en_o.
- Timeout:
  - The idle counter increments each cycle in RECV while byte_cnt!=0 and rx_done_i=0; it clears on any strobe.
  - When it reaches TIMEOUT_CYC-1: discard the partial word, pulse timeout_o, clear loading_o, → IDLE.
  - No words already written are undone; words_loaded_o keeps its count.
  - With byte_cnt==0 in RECV, wait indefinitely.
- CMD_LOAD value received in RECV is treated as data, not as a restart.
- wr_addr_o and wr_data_o hold their last values outside WRITE.
- Reset asserted mid-load: next cycle IDLE, outputs 0; any write in flight is dropped.

Decomposition:
- Shared package (debug/loader constants): state encoding (IDLE, RECV, WRITE, DONE), CMD_LOAD and the other debug command byte codes, HALT_WORD, and the TIMEOUT_CYC default. The same constants are used by the debug unit and the decode halt detection.
- No sub-module needed. The byte assembler (shift register plus 2-bit counter) stays inline; optionally factor it as byte_to_word_packer if reused for the data-memory dump path.

Test Plan:
- Reset mid-operation: send CMD_LOAD and 2 bytes, then hold reset_i=0 for 1 cycle → all outputs 0, state IDLE. The next 4 bytes produce no write until a new CMD_LOAD.
- Basic load: send 8'h4C, then bytes 20 08 00 05, then FF FF FF FF → two writes: addr0=32'h2008_0005, addr1=32'hFFFF_FFFF. load_done_o pulses 1 cycle after the 2nd wr_en_o; words_loaded_o=2; full_o=0.
- Noise before command: send bytes 8'h12, 8'h00, then 8'h4C and 4 bytes → no write before CMD_LOAD; the first write is at addr0.
- Back-to-back strobes: rx_done_i on consecutive cycles for 8 bytes 01..08, with the 5th strobe coinciding with WRITE → writes 32'h0102_0304 at addr0 and 32'h0506_0708 at addr1; no byte lost.
- Memory full: 128 non-halt words of 32'h0000_0001 → wr_addr_o reaches 127, full_o=1, load_done_o pulses, words_loaded_o=128, loading_o=0.
- Timeout: CMD_LOAD, one full word, then 2 bytes and silence of TIMEOUT_CYC cycles (TIMEOUT_CYC=16 in the bench) → timeout_o pulses once, no 2nd write, words_loaded_o=1, state IDLE.
